// File: rtl/sd_multiblock_ctrl_if.sv
// CPU bus, SD engine and sector-buffer port-B signals of sd_multiblock_ctrl.
// slave = the controller, master = bus decoder / engine / buffer side.
interface sd_multiblock_ctrl_if #(parameter int SECTOR_BITS = 9);
  logic                   sd_cs;
  logic                   R_W_n;
  logic [7:0]             reg_addr_i;
  logic [7:0]             data_i;
  logic [7:0]             data_o;
  logic                   irq_o;
  logic                   rstart_o;
  logic                   wstart_o;
  logic [31:0]            sector_o;
  logic                   rbusy_i;
  logic [3:0]             card_stat_i;
  logic [1:0]             card_type_i;
  logic [SECTOR_BITS-1:0] buf_addr_o;
  logic                   buf_we_o;
  logic [7:0]             buf_din_o;
  logic [7:0]             buf_dout_i;

  modport slave (
    input  sd_cs, R_W_n, reg_addr_i, data_i, rbusy_i, card_stat_i, card_type_i, buf_dout_i,
    output data_o, irq_o, rstart_o, wstart_o, sector_o, buf_addr_o, buf_we_o, buf_din_o
  );

  modport master (
    output sd_cs, R_W_n, reg_addr_i, data_i, rbusy_i, card_stat_i, card_type_i, buf_dout_i,
    input  data_o, irq_o, rstart_o, wstart_o, sector_o, buf_addr_o, buf_we_o, buf_din_o
  );
endinterface

// File: rtl/sd_multiblock_ctrl.sv
// 6502-bus register file and multi-sector transfer sequencer driving the SD
// engine and port B of the sector buffer.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | no transfer; LBA/count writable, start accepted
// S_ISSUE     | one-cycle rstart_o/wstart_o pulse for the current LBA
// S_WAIT_BUSY | waiting for the engine to raise rbusy_i (timed)
// S_WAIT_DONE | waiting for the engine to drop rbusy_i (timed)
// S_ADVANCE   | LBA += 1, remaining -= 1; last sector ends the transfer
// S_HOLD      | buffer handed to the CPU until continue or abort
module sd_multiblock_ctrl #(
  parameter int WIN_BITS    = 7,
  parameter int SECTOR_BITS = 9,
  parameter int COUNT_W     = 8,
  parameter int TIMEOUT_CYC = 4_000_000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sd_multiblock_ctrl_if.slave  bus
);
  localparam int PAGE_BITS = SECTOR_BITS - WIN_BITS;
  localparam int TMR_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_ADVANCE, S_HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            lba_q, lba_d;
  logic [COUNT_W-1:0]     count_q, count_d;
  logic [COUNT_W-1:0]     remaining_q, remaining_d;
  logic [PAGE_BITS-1:0]   page_q, page_d;
  logic                   irq_en_q, irq_en_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   timeout_q, timeout_d;
  logic                   dir_q, dir_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [SECTOR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic                   buf_we_q, buf_we_d;
  logic                   irq_q, irq_d;

  logic cpu_wr, reg_wr, win_wr;
  logic start_req, cont_req, abort_req, stat_clr;
  logic waiting, tmr_zero;

  assign cpu_wr    = bus.sd_cs & ~bus.R_W_n;
  assign reg_wr    = cpu_wr & ~bus.reg_addr_i[7];
  assign win_wr    = cpu_wr &  bus.reg_addr_i[7];
  assign start_req = reg_wr & ((bus.reg_addr_i == 8'h05) | (bus.reg_addr_i == 8'h06));
  assign cont_req  = reg_wr & (bus.reg_addr_i == 8'h0B);
  assign abort_req = reg_wr & (bus.reg_addr_i == 8'h0D);
  assign stat_clr  = reg_wr & (bus.reg_addr_i == 8'h04);
  assign waiting   = (state_q == S_WAIT_BUSY) | (state_q == S_WAIT_DONE);
  assign tmr_zero  = (timer_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start_req) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (bus.rbusy_i) state_d = S_WAIT_DONE;
                   else if (tmr_zero) state_d = S_IDLE;
      S_WAIT_DONE: if (!bus.rbusy_i) state_d = S_ADVANCE;
                   else if (tmr_zero) state_d = S_IDLE;
      S_ADVANCE:   state_d = (remaining_q == COUNT_W'(1)) ? S_IDLE : S_HOLD;
      S_HOLD:      if (cont_req) state_d = S_ISSUE;
                   else if (abort_req) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lba_q       <= '0;
      count_q     <= COUNT_W'(1);
      remaining_q <= '0;
      page_q      <= '0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      timeout_q   <= 1'b0;
      dir_q       <= 1'b0;
      timer_q     <= TMR_LOAD;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      buf_we_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      lba_q       <= lba_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      page_q      <= page_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      error_q     <= error_d;
      timeout_q   <= timeout_d;
      dir_q       <= dir_d;
      timer_q     <= timer_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      buf_we_q    <= buf_we_d;
      irq_q       <= irq_d;
    end
  end

  always_comb begin
    lba_d       = lba_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    page_d      = page_q;
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    error_d     = error_q;
    timeout_d   = timeout_q;
    dir_d       = dir_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    buf_we_d    = win_wr;
    irq_d       = irq_en_q & (done_q | error_q | (state_q == S_HOLD));
    // the timer idles at its load value and only counts while a wait persists
    timer_d     = (waiting && state_d == state_q) ? timer_q - TMR_W'(1) : TMR_LOAD;

    if (win_wr) begin
      wr_addr_d = {page_q, bus.reg_addr_i[WIN_BITS-1:0]};
      wr_data_d = bus.data_i;
    end

    if (reg_wr) begin
      case (bus.reg_addr_i)
        8'h00: if (state_q == S_IDLE) lba_d[7:0]   = bus.data_i;
        8'h01: if (state_q == S_IDLE) lba_d[15:8]  = bus.data_i;
        8'h02: if (state_q == S_IDLE) lba_d[23:16] = bus.data_i;
        8'h03: if (state_q == S_IDLE) lba_d[31:24] = bus.data_i;
        8'h07: page_d = bus.data_i[PAGE_BITS-1:0];
        8'h0A: if (state_q == S_IDLE) count_d = COUNT_W'(bus.data_i);
        8'h0C: irq_en_d = bus.data_i[0];
        default: ;
      endcase
    end

    if (stat_clr || (state_q == S_IDLE && start_req)) begin
      done_d    = 1'b0;
      error_d   = 1'b0;
      timeout_d = 1'b0;
    end

    if (state_q == S_IDLE && start_req) begin
      dir_d       = (bus.reg_addr_i == 8'h06);
      remaining_d = (count_q == '0) ? COUNT_W'(1) : count_q;
    end

    // flag sets come last so they win over a same-cycle status clear
    if (state_q == S_ADVANCE) begin
      lba_d       = lba_q + 32'd1;
      remaining_d = remaining_q - COUNT_W'(1);
      if (remaining_q == COUNT_W'(1)) done_d = 1'b1;
    end
    if (state_q == S_HOLD && !cont_req && abort_req) done_d = 1'b1;
    if (waiting && state_d == S_IDLE) begin
      error_d   = 1'b1;
      timeout_d = 1'b1;
    end
  end

  always_comb begin
    bus.rstart_o   = (state_q == S_ISSUE) & ~dir_q;
    bus.wstart_o   = (state_q == S_ISSUE) &  dir_q;
    bus.sector_o   = lba_q;
    bus.irq_o      = irq_q;
    bus.buf_we_o   = buf_we_q;
    bus.buf_din_o  = wr_data_q;
    bus.buf_addr_o = buf_we_q ? wr_addr_q : {page_q, bus.reg_addr_i[WIN_BITS-1:0]};
    bus.data_o     = 8'h00;
    if (bus.reg_addr_i[7]) begin
      bus.data_o = bus.buf_dout_i;
    end else begin
      case (bus.reg_addr_i)
        8'h00: bus.data_o = lba_q[7:0];
        8'h01: bus.data_o = lba_q[15:8];
        8'h02: bus.data_o = lba_q[23:16];
        8'h03: bus.data_o = lba_q[31:24];
        8'h04: bus.data_o = {2'b00, timeout_q, error_q, done_q, (state_q == S_HOLD),
                             (state_q != S_IDLE), bus.rbusy_i};
        8'h07: bus.data_o = 8'(page_q);
        8'h08: bus.data_o = {4'b0000, bus.card_stat_i};
        8'h09: bus.data_o = {6'b000000, bus.card_type_i};
        8'h0A: bus.data_o = 8'(remaining_q);
        8'h0C: bus.data_o = {7'b0000000, irq_en_q};
        default: bus.data_o = 8'h00;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_multiblock_ctrl.sv
// Randomized scoreboard bench for sd_multiblock_ctrl: a transaction-level model
// queues expected start pulses, buffer writes and register reads for a monitor.
module tb_sd_multiblock_ctrl;
  logic clk = 1'b0;
  logic rst;

  sd_multiblock_ctrl_if #(.SECTOR_BITS(9)) bus ();

  sd_multiblock_ctrl #(
    .WIN_BITS(7), .SECTOR_BITS(9), .COUNT_W(8), .TIMEOUT_CYC(64)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // sector buffer port B, written only through the DUT
  logic [7:0] ram [512];
  assign bus.buf_dout_i = ram[bus.buf_addr_o];
  always @(posedge clk) if (bus.buf_we_o) ram[bus.buf_addr_o] <= bus.buf_din_o;

  typedef struct packed { logic dir; logic [31:0] lba; } start_t;
  typedef struct packed { logic [8:0] addr; logic [7:0] data; } bwr_t;
  typedef struct packed { logic win; logic [8:0] baddr; logic [7:0] data; } rd_t;

  start_t start_q[$];
  bwr_t   bwr_q[$];
  rd_t    rd_q[$];

  int n_vec  = 0;
  int n_miss = 0;

  // reference model
  bit [31:0] m_lba;
  int        m_count, m_rem;
  bit [1:0]  m_page;
  bit        m_irq_en, m_done, m_err, m_to, m_hold, m_active;
  bit        busy;
  logic [7:0] m_mem [512];
  logic [3:0] cstat;
  logic [1:0] ctype;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: DUT event with nothing expected", name);
  endfunction

  function automatic logic [7:0] stat_exp();
    return {2'b00, m_to, m_err, m_done, m_hold, m_active, busy};
  endfunction

  function automatic logic irq_exp();
    return m_irq_en & (m_done | m_err | m_hold);
  endfunction

  always @(negedge clk) begin
    start_t s;
    bwr_t   b;
    rd_t    r;
    if (!rst) begin
      if (bus.rstart_o || bus.wstart_o) begin
        if (start_q.size() == 0) unexpected("start_pulse");
        else begin
          s = start_q.pop_front();
          check("start_dir", {30'd0, bus.wstart_o, bus.rstart_o}, s.dir ? 32'd2 : 32'd1);
          check("sector_o", bus.sector_o, s.lba);
        end
      end
      if (bus.buf_we_o) begin
        if (bwr_q.size() == 0) unexpected("buf_we_o");
        else begin
          b = bwr_q.pop_front();
          check("buf_wr_addr", 32'(bus.buf_addr_o), 32'(b.addr));
          check("buf_wr_data", 32'(bus.buf_din_o), 32'(b.data));
        end
      end
      if (bus.sd_cs && bus.R_W_n) begin
        if (rd_q.size() == 0) unexpected("cpu_read");
        else begin
          r = rd_q.pop_front();
          check("data_o", 32'(bus.data_o), 32'(r.data));
          if (r.win) check("buf_rd_addr", 32'(bus.buf_addr_o), 32'(r.baddr));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.sd_cs = 1'b1; bus.R_W_n = 1'b0; bus.reg_addr_i = a; bus.data_i = d;
    tick();
    bus.sd_cs = 1'b0; bus.R_W_n = 1'b1;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input logic [8:0] baddr = 9'd0);
    rd_q.push_back('{win: a[7], baddr: baddr, data: exp});
    bus.sd_cs = 1'b1; bus.R_W_n = 1'b1; bus.reg_addr_i = a;
    tick();
    bus.sd_cs = 1'b0;
  endtask

  task automatic set_lba(input bit [31:0] v);
    for (int i = 0; i < 4; i++) wr(8'(i), v[8*i +: 8]);
    m_lba = v;
  endtask

  task automatic chk_lba();
    for (int i = 0; i < 4; i++) rd(8'(i), m_lba[8*i +: 8]);
  endtask

  task automatic set_count(input int c);
    wr(8'h0A, 8'(c));
    m_count = c;
  endtask

  task automatic set_irq(input bit e);
    wr(8'h0C, {7'd0, e});
    m_irq_en = e;
    rd(8'h0C, {7'd0, e});
  endtask

  task automatic do_start(input bit dir);
    start_q.push_back('{dir: dir, lba: m_lba});
    wr(dir ? 8'h06 : 8'h05, 8'h00);
    m_done = 0; m_err = 0; m_to = 0; m_hold = 0; m_active = 1;
    m_rem = (m_count == 0) ? 1 : m_count;
  endtask

  task automatic wait_start(output bit ok);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rstart_o || bus.wstart_o) begin ok = 1; break; end
      tick();
    end
    if (!ok) unexpected("start_wait_expired");
  endtask

  task automatic serve(input bit guard);
    bit ok;
    wait_start(ok);
    if (!ok) return;
    tick($urandom_range(1, 3));
    busy = 1'b1; bus.rbusy_i = 1'b1;
    tick(2);
    rd(8'h04, stat_exp());
    if (guard) begin
      wr(8'h00, 8'($urandom));
      wr(8'h0A, 8'($urandom));
      wr(8'h05, 8'h00);
      wr(8'h06, 8'h00);
    end
    tick($urandom_range(1, 15));
    busy = 1'b0; bus.rbusy_i = 1'b0;
    tick(3);
    m_lba = m_lba + 1;
    m_rem = m_rem - 1;
    if (m_rem == 0) begin m_done = 1; m_active = 0; end
    else m_hold = 1;
    rd(8'h04, stat_exp());
    rd(8'h0A, 8'(m_rem));
    check("irq_o", 32'(bus.irq_o), 32'(irq_exp()));
  endtask

  task automatic buf_write(input bit [1:0] pg, input bit [6:0] off, input logic [7:0] d);
    bwr_q.push_back('{addr: {pg, off}, data: d});
    wr({1'b1, off}, d);
    m_mem[{pg, off}] = d;
    tick();
    rd({1'b1, off}, d, {pg, off});
  endtask

  task automatic window_ops();
    bit [1:0] pg;
    pg = 2'($urandom_range(0, 3));
    wr(8'h07, {6'd0, pg});
    m_page = pg;
    rd(8'h07, {6'd0, pg});
    repeat ($urandom_range(1, 2)) buf_write(m_page, 7'($urandom), 8'($urandom));
  endtask

  task automatic transfer(input bit dir, input int cnt, input bit may_abort);
    set_count(cnt);
    do_start(dir);
    for (int s = 0; s < 16; s++) begin
      serve(s == 0 || $urandom_range(0, 1) == 1);
      if (!m_hold) break;
      window_ops();
      if (may_abort && $urandom_range(0, 2) == 0) begin
        wr(8'h0D, 8'h00);
        m_hold = 0; m_done = 1; m_active = 0;
        tick(2);
        rd(8'h04, stat_exp());
        rd(8'h0A, 8'(m_rem));
        break;
      end
      m_hold = 0;
      start_q.push_back('{dir: dir, lba: m_lba});
      wr(8'h0B, 8'h00);
    end
    tick(2);
    check("irq_o_end", 32'(bus.irq_o), 32'(irq_exp()));
    chk_lba();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ok;
    cstat = 4'($urandom);
    ctype = 2'($urandom);
    rst = 1'b1;
    bus.sd_cs = 1'b0; bus.R_W_n = 1'b1; bus.reg_addr_i = 8'h00; bus.data_i = 8'h00;
    bus.rbusy_i = 1'b0; bus.card_stat_i = cstat; bus.card_type_i = ctype;
    busy = 0;
    m_lba = 0; m_count = 1; m_rem = 0; m_page = 0; m_irq_en = 0;
    m_done = 0; m_err = 0; m_to = 0; m_hold = 0; m_active = 0;
    tick(3);
    rst = 1'b0;
    tick();

    // reset state and static registers
    check("irq_o_reset", 32'(bus.irq_o), 32'(irq_exp()));
    rd(8'h04, stat_exp());
    rd(8'h0A, 8'(m_rem));
    rd(8'h07, 8'h00);
    rd(8'h0C, 8'h00);
    chk_lba();
    rd(8'h08, {4'd0, cstat});
    rd(8'h09, {6'd0, ctype});
    rd(8'h0E, 8'h00);
    rd(8'h05, 8'h00);

    // single read
    set_lba(32'h0000_0010);
    set_irq(1'b1);
    transfer(1'b0, 1, 1'b0);

    // multi-sector write
    set_irq(1'b0);
    set_lba(32'h1234_5678);
    transfer(1'b1, 3, 1'b0);

    // window access at page 2
    wr(8'h07, 8'h02);
    m_page = 2'd2;
    buf_write(2'd2, 7'h05, 8'hA5);

    // timeout with rbusy_i stuck high
    set_irq(1'b1);
    set_lba(32'hCAFE_0000);
    set_count(2);
    do_start(1'b0);
    wait_start(ok);
    tick();
    busy = 1'b1; bus.rbusy_i = 1'b1;
    tick(50);
    rd(8'h04, stat_exp());
    tick(20);
    m_err = 1; m_to = 1; m_active = 0;
    rd(8'h04, stat_exp());
    rd(8'h0A, 8'(m_rem));
    chk_lba();
    check("irq_o_timeout", 32'(bus.irq_o), 32'(irq_exp()));
    wr(8'h04, 8'h00);
    m_err = 0; m_to = 0;
    rd(8'h04, stat_exp());
    busy = 1'b0; bus.rbusy_i = 1'b0;
    tick(2);

    // timeout with the engine never going busy
    do_start(1'b1);
    wait_start(ok);
    tick(30);
    rd(8'h04, stat_exp());
    tick(40);
    m_err = 1; m_to = 1; m_active = 0;
    rd(8'h04, stat_exp());
    chk_lba();
    wr(8'h04, 8'h00);
    m_err = 0; m_to = 0;
    rd(8'h04, stat_exp());

    // LBA wrap
    set_lba(32'hFFFF_FFFF);
    transfer(1'b0, 2, 1'b0);

    // randomized transfers
    for (int t = 0; t < 12; t++) begin
      set_irq(1'($urandom));
      set_lba($urandom);
      transfer(1'($urandom), $urandom_range(0, 4), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        wr(8'h04, 8'h00);
        m_done = 0;
        rd(8'h04, stat_exp());
        tick(2);
        check("irq_o_clear", 32'(bus.irq_o), 32'(irq_exp()));
      end
    end

    // reset while holding mid-transfer
    set_irq(1'b1);
    set_lba(32'h0000_0A00);
    set_count(3);
    do_start(1'b1);
    serve(1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_lba = 0; m_count = 1; m_rem = 0; m_page = 0; m_irq_en = 0;
    m_done = 0; m_err = 0; m_to = 0; m_hold = 0; m_active = 0;
    check("irq_o_after_reset", 32'(bus.irq_o), 32'(irq_exp()));
    rd(8'h04, stat_exp());
    rd(8'h0A, 8'(m_rem));
    rd(8'h07, 8'h00);
    rd(8'h0C, 8'h00);
    chk_lba();
    tick(5);
    do_start(1'b0);
    serve(1'b0);
    tick(2);
    chk_lba();

    tick(4);
    check("start_q_left", start_q.size(), 0);
    check("bwr_q_left", bwr_q.size(), 0);
    check("rd_q_left", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/sd_multiblock_ctrl.md
# sd_multiblock_ctrl

Parametrised successor to the nano6502 SD-card register interface: a 6502-bus register file plus a multi-sector transfer sequencer that drives the SD engine (`sd_rw`) and an external sector dual-port RAM.

- Adds a sector count, LBA auto-increment and a per-sector CPU hand-off.
- Adds sticky done/error flags, an engine timeout and a level interrupt.
- Sits between the CPU bus decoder (`sd_cs`) and `sd_rw` plus the `sector_dpram` port B.

## Interface
Parameters:
- WIN_BITS, 7: CPU window size is 2^WIN_BITS bytes at 0x80; must be ≤7.
- SECTOR_BITS, 9: sector buffer address width (512 B).
- COUNT_W, 8: sector count register width.
- TIMEOUT_CYC, 4_000_000: maximum cycles in WAIT_BUSY or WAIT_DONE.
- Derived: PAGE_BITS = SECTOR_BITS − WIN_BITS.

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- sd_cs  in  1  register block select
- R_W_n  in  1  1 = read, 0 = write
- reg_addr_i  in  8  register offset
- data_i  in  8  CPU write data
- data_o  out  8  CPU read data (combinational)
- irq_o  out  1  level interrupt
- rstart_o / wstart_o  out  1  one-cycle engine start pulses
- sector_o  out  32  LBA to engine
- rbusy_i  in  1  engine busy
- card_stat_i  in  4; card_type_i  in  2  engine status
- buf_addr_o  out  SECTOR_BITS  buffer port-B address
- buf_we_o  out  1; buf_din_o  out  8; buf_dout_i  in  8  buffer port B

## Operation
Register map (write = `sd_cs` & !R_W_n sampled at a rising edge):
- 00–03: LBA, LSB first. Read/write. Writes are ignored unless IDLE.
- 04: status, read `{2'b0, timeout, error, done, wait_cpu, active, rbusy_i}`. Any write clears done, error and timeout.
- 05 / 06: start read / start write. Honoured only in IDLE. Clears done, error and timeout. Loads remaining = count, with count 0 treated as 1.
- 07: page (PAGE_BITS, zero-extended on read, truncated on write). Writable in any state.
- 08: `{4'b0, card_stat_i}`. 09: `{6'b0, card_type_i}`.
- 0A: count. Write sets the count (ignored unless IDLE). Read returns remaining sectors.
- 0B: continue. Honoured only in HOLD.
- 0C: bit0 irq_en.
- 0D: abort. Honoured only in HOLD; sets done and goes to IDLE.
- 80–FF: buffer window. Read: buf_addr_o = {page, reg_addr_i[WIN_BITS-1:0]} combinationally, data_o = buf_dout_i. Write: address and data are registered, and buf_we_o pulses the next cycle.
- Unmapped reads return 0.

States:
- IDLE → ISSUE on a start write.
- ISSUE: rstart_o or wstart_o high for exactly this one cycle → WAIT_BUSY.
- WAIT_BUSY: wait for rbusy_i = 1 → WAIT_DONE.
- WAIT_DONE: wait for rbusy_i = 0 → ADVANCE.
- ADVANCE: LBA += 1 (32-bit wrap), remaining −= 1. If the new remaining is 0 → IDLE with done = 1; otherwise → HOLD.
- HOLD: wait_cpu = 1. The CPU consumes (read) or refills (write) the buffer, then writes 0B → ISSUE with the same direction.
- Timeout: a timer clears on entry to WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT_CYC: error = 1, timeout = 1 → IDLE. LBA and remaining are frozen at the failing sector.

Outputs and flags:
- active = (state ≠ IDLE).
- sector_o = LBA register, constant from ISSUE through WAIT_DONE.
- irq_o = irq_en & (done | error | wait_cpu), registered.

Reset (rst_i high at an edge): state IDLE, LBA 0, count 1, remaining 0, page 0, irq_en 0, all flags 0, rstart_o = wstart_o = buf_we_o = irq_o = 0.
- Reset mid-transfer abandons the sequence. The engine is not notified.

## Timing
- Start write sampled at edge N: ISSUE in cycle N..N+1 with the start pulse high. WAIT_BUSY from edge N+1.
- rbusy_i falls, sampled at edge M: ADVANCE after M, and HOLD or IDLE after M+1. done and wait_cpu are visible on status at M+1. irq_o is visible one cycle later (M+2).
- Continue at edge K: start pulse in cycle K..K+1.
- Buffer write at edge N: buf_we_o, buf_addr_o and buf_din_o valid in cycle N..N+1.
- Simultaneous events:
  - Status-clear write in the same cycle done is set: set wins.
  - Abort and continue can never coincide (single bus).
- A pulse of rbusy_i shorter than one cycle is not required to be caught.

## Test plan
- Single read: LBA = 0x00000010, count = 1, write 05; engine busy for 20 cycles. Expect exactly one rstart_o pulse, sector_o = 0x10, then done = 1, LBA = 0x11, remaining 0, irq_o = 1 only if irq_en.
- Multi write: count = 3, write 06; respond to 3 sectors, issuing continue after each HOLD. Expect wstart_o pulses at LBA n, n+1, n+2, HOLD twice, final done, LBA = n+3.
- Window access: page = 2; CPU write 0xA5 to 0x85. Expect buf_we_o one cycle later with buf_addr_o = 0x105 and buf_din_o = 0xA5. Read at 0x85 drives buf_addr_o = 0x105.
- Timeout: TIMEOUT_CYC = 64, rbusy_i stuck high. Expect error = 1 and timeout = 1 after 64 cycles in WAIT_DONE, IDLE, LBA unchanged; a write to 04 clears both.
- Guarding: writes to 00, 0A, 05 and 06 during WAIT_DONE are ignored. Abort in HOLD gives IDLE, done = 1, remaining preserved.
- Reset mid-sequence in HOLD: all registers at reset values next cycle, irq_o = 0, no start pulse.
